// File: rtl/crp16_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crp16_mem_pkg
// Brief    : Shared encodings and default widths for the crp16 memory arbiter
// Revision : 1.0 - initial release
// ============================================================================
package crp16_mem_pkg;

  localparam int unsigned CRP16_ADDR_W = 16;
  localparam int unsigned CRP16_DATA_W = 16;

  // Ownership state of the single RAM port
  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DEBUG  = 2'd2
  } arb_state_t;

  // Which requester owns the read currently in flight
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2,
    TAG_DBG  = 2'd3
  } owner_tag_t;

endpackage
`default_nettype wire

// File: rtl/crp16_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : crp16_mem_arbiter_if
// Brief    : Requester handshakes and RAM macro port bundled for the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface crp16_mem_arbiter_if
  import crp16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = CRP16_ADDR_W,
  parameter int unsigned DATA_W = CRP16_DATA_W
);

  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  // Data load/store requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;

  // Debug / loader requester
  logic              dbg_hold;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic              dbg_active;

  // Shared read return and RAM macro port
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  dbg_hold, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  ram_q,
    output if_gnt, if_rvalid,
    output dm_gnt, dm_rvalid,
    output dbg_gnt, dbg_rvalid, dbg_active,
    output rdata, ram_addr, ram_wdata, ram_wren
  );

  // Requesters plus RAM macro side
  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output dbg_hold, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output ram_q,
    input  if_gnt, if_rvalid,
    input  dm_gnt, dm_rvalid,
    input  dbg_gnt, dbg_rvalid, dbg_active,
    input  rdata, ram_addr, ram_wdata, ram_wren
  );

endinterface
`default_nettype wire

// File: rtl/crp16_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : crp16_rr_arb2
// Brief    : Two-input round-robin arbiter (bit 0 = fetch, bit 1 = data)
// Revision : 1.0 - initial release
// ============================================================================
module crp16_rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when the data side won the most recent grant; reset to data so
  // fetch wins the first tie.
  logic r_last_dm;

  // One-hot grant: on a tie the side that did not win last time goes first
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || r_last_dm)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // Remember the winner of every grant actually issued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_dm <= 1'b1;
    end else if (gnt[0]) begin
      r_last_dm <= 1'b0;
    end else if (gnt[1]) begin
      r_last_dm <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/crp16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : crp16_mem_arbiter
// Brief    : Shares one single-port synchronous RAM between CPU fetch, CPU
//            data and a debug/loader port that can take exclusive ownership
// Revision : 1.0 - initial release
// ============================================================================
module crp16_mem_arbiter
  import crp16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = CRP16_ADDR_W,
  parameter int unsigned DATA_W = CRP16_DATA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  crp16_mem_arbiter_if.slave bus
);

  arb_state_t        r_state;
  logic              r_dbg_active;
  owner_tag_t        r_tag;
  owner_tag_t        w_tag_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_cpu_en;
  logic [1:0]        w_cpu_req;
  logic [1:0]        w_cpu_gnt;
  logic              w_if_gnt;
  logic              w_dm_gnt;
  logic              w_dbg_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wren;

  // CPU grants only in NORMAL; reset_n gating keeps every grant low while
  // reset is asserted even though the state already reads NORMAL.
  assign w_cpu_en  = reset_n && (r_state == ST_NORMAL);
  assign w_cpu_req = {bus.dm_req, bus.if_req};

  crp16_rr_arb2 u_rr_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (w_cpu_en),
    .req     (w_cpu_req),
    .gnt     (w_cpu_gnt)
  );

  assign w_if_gnt  = w_cpu_gnt[0];
  assign w_dm_gnt  = w_cpu_gnt[1];
  assign w_dbg_gnt = (r_state == ST_DEBUG) && bus.dbg_req;

  // Steer the granted requester onto the RAM port and work out which read,
  // if any, returns next cycle. With no grant the address and data hold.
  always_comb begin
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_wren     = 1'b0;
    w_tag_next = TAG_NONE;
    if (w_if_gnt) begin
      w_addr     = bus.if_addr;
      w_tag_next = TAG_IF;
    end else if (w_dm_gnt) begin
      w_addr = bus.dm_addr;
      if (bus.dm_we) begin
        w_wdata = bus.dm_wdata;
        w_wren  = 1'b1;
      end else begin
        w_tag_next = TAG_DM;
      end
    end else if (w_dbg_gnt) begin
      w_addr = bus.dbg_addr;
      if (bus.dbg_we) begin
        w_wdata = bus.dbg_wdata;
        w_wren  = 1'b1;
      end else begin
        w_tag_next = TAG_DBG;
      end
    end
  end

  // Read-owner tag plus the held RAM address/data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag   <= TAG_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_tag   <= w_tag_next;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  // Ownership FSM: NORMAL -> DRAIN -> DEBUG -> NORMAL, dbg_active registered
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_NORMAL;
      r_dbg_active <= 1'b0;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (bus.dbg_hold) begin
            r_state      <= ST_DRAIN;
            r_dbg_active <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!bus.dbg_hold) begin
            r_state      <= ST_NORMAL;
            r_dbg_active <= 1'b0;
          end else if (w_tag_next == TAG_NONE) begin
            r_state      <= ST_DEBUG;
            r_dbg_active <= 1'b1;
          end
        end
        ST_DEBUG: begin
          // A debug read granted this cycle keeps DEBUG until it returns
          if (!bus.dbg_hold && (w_tag_next != TAG_DBG)) begin
            r_state      <= ST_NORMAL;
            r_dbg_active <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_NORMAL;
          r_dbg_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt     = w_if_gnt;
  assign bus.dm_gnt     = w_dm_gnt;
  assign bus.dbg_gnt    = w_dbg_gnt;
  assign bus.if_rvalid  = (r_tag == TAG_IF);
  assign bus.dm_rvalid  = (r_tag == TAG_DM);
  assign bus.dbg_rvalid = (r_tag == TAG_DBG);
  assign bus.dbg_active = r_dbg_active;
  assign bus.rdata      = bus.ram_q;
  assign bus.ram_addr   = w_addr;
  assign bus.ram_wdata  = w_wdata;
  assign bus.ram_wren   = w_wren;

endmodule
`default_nettype wire

// File: tb/tb_crp16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_crp16_mem_arbiter
// Brief    : Directed self-checking bench for crp16_mem_arbiter with a
//            behavioural 1-cycle-latency RAM
// Revision : 1.0 - initial release
// ============================================================================
module tb_crp16_mem_arbiter;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  logic [15:0] mem [0:1023];

  crp16_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  crp16_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural single-port RAM, read data valid the cycle after the address
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_addr[9:0]];
  end

  // Wall-clock guard
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [2:0] gnts();
    return {bus.if_gnt, bus.dm_gnt, bus.dbg_gnt};
  endfunction

  function automatic logic [2:0] rvs();
    return {bus.if_rvalid, bus.dm_rvalid, bus.dbg_rvalid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] exp_rd;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] <= 16'hA000 + 16'(i);
    mem[16'h0010] <= 16'h1234;

    reset_n       = 1'b0;
    bus.if_req    = 1'b1;
    bus.if_addr   = 16'h0010;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 16'h0000;
    bus.dm_wdata  = 16'h0000;
    bus.dbg_hold  = 1'b0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 16'h0000;
    bus.dbg_wdata = 16'h0000;

    // Reset state, with a fetch request pending
    cyc(); #2;
    chk("rst_gnt", 32'(gnts()), 32'h0);
    chk("rst_rv", 32'(rvs()), 32'h0);
    chk("rst_wren", 32'(bus.ram_wren), 32'h0);
    chk("rst_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_wdata", 32'(bus.ram_wdata), 32'h0);
    chk("rst_active", 32'(bus.dbg_active), 32'h0);

    // Contention: fetch 0x0020 vs data read 0x0200, IF first after reset
    cyc();
    reset_n = 1'b1;
    bus.if_addr = 16'h0020;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 16'h0200;
    #2;
    chk("c1_gnt", 32'(gnts()), 32'b100);
    chk("c1_rv", 32'(rvs()), 32'b000);
    chk("c1_addr", 32'(bus.ram_addr), 32'h0020);
    cyc(); #2;
    chk("c2_gnt", 32'(gnts()), 32'b010);
    chk("c2_rv", 32'(rvs()), 32'b100);
    chk("c2_rdata", 32'(bus.rdata), 32'hA020);
    chk("c2_addr", 32'(bus.ram_addr), 32'h0200);
    cyc(); #2;
    chk("c3_gnt", 32'(gnts()), 32'b100);
    chk("c3_rv", 32'(rvs()), 32'b010);
    chk("c3_rdata", 32'(bus.rdata), 32'hA200);
    cyc(); #2;
    chk("c4_gnt", 32'(gnts()), 32'b010);
    chk("c4_rv", 32'(rvs()), 32'b100);
    chk("c4_rdata", 32'(bus.rdata), 32'hA020);
    cyc();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    #2;
    chk("c5_gnt", 32'(gnts()), 32'b000);
    chk("c5_rv", 32'(rvs()), 32'b010);
    chk("c5_rdata", 32'(bus.rdata), 32'hA200);
    chk("c5_hold_addr", 32'(bus.ram_addr), 32'h0200);
    chk("c5_wren", 32'(bus.ram_wren), 32'h0);

    // Fetch-only: 0x0010 then four back-to-back fetches
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    #2;
    chk("f0_gnt", 32'(gnts()), 32'b100);
    chk("f0_rv", 32'(rvs()), 32'b000);
    chk("f0_addr", 32'(bus.ram_addr), 32'h0010);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      bus.if_addr = 16'h0010 + 16'(i);
      #2;
      exp_rd = (i == 1) ? 16'h1234 : 16'hA010 + 16'(i - 1);
      chk("fb_gnt", 32'(gnts()), 32'b100);
      chk("fb_rv", 32'(rvs()), 32'b100);
      chk("fb_rdata", 32'(bus.rdata), 32'(exp_rd));
    end
    cyc();
    bus.if_req = 1'b0;
    #2;
    chk("f5_rv", 32'(rvs()), 32'b100);
    chk("f5_rdata", 32'(bus.rdata), 32'hA014);
    chk("f5_gnt", 32'(gnts()), 32'b000);
    chk("f5_hold_addr", 32'(bus.ram_addr), 32'h0014);

    // Data write 0x0300 = 0xBEEF, then fetch it back
    cyc();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0300;
    bus.dm_wdata = 16'hBEEF;
    #2;
    chk("w1_gnt", 32'(gnts()), 32'b010);
    chk("w1_wren", 32'(bus.ram_wren), 32'h1);
    chk("w1_addr", 32'(bus.ram_addr), 32'h0300);
    chk("w1_wdata", 32'(bus.ram_wdata), 32'hBEEF);
    chk("w1_rv", 32'(rvs()), 32'b000);
    cyc();
    bus.dm_req  = 1'b0;
    bus.dm_we   = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0300;
    #2;
    chk("w2_gnt", 32'(gnts()), 32'b100);
    chk("w2_wren", 32'(bus.ram_wren), 32'h0);
    chk("w2_rv", 32'(rvs()), 32'b000);
    chk("w2_wdata_hold", 32'(bus.ram_wdata), 32'hBEEF);
    cyc();
    bus.if_req = 1'b0;
    #2;
    chk("w3_rv", 32'(rvs()), 32'b100);
    chk("w3_rdata", 32'(bus.rdata), 32'hBEEF);

    // dbg_req in NORMAL is ignored
    cyc();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 16'h0000;
    #2;
    chk("dn1_gnt", 32'(gnts()), 32'b000);
    chk("dn1_active", 32'(bus.dbg_active), 32'h0);
    cyc(); #2;
    chk("dn2_gnt", 32'(gnts()), 32'b000);
    chk("dn2_rv", 32'(rvs()), 32'b000);

    // Debug takeover with a fetch granted in the cycle hold rises
    cyc();
    bus.dbg_req  = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h0011;
    bus.dbg_hold = 1'b1;
    #2;
    chk("t1_gnt", 32'(gnts()), 32'b100);
    chk("t1_active", 32'(bus.dbg_active), 32'h0);
    cyc();
    bus.if_addr = 16'h0012;
    #2;
    chk("t2_drain_gnt", 32'(gnts()), 32'b000);
    chk("t2_rv", 32'(rvs()), 32'b100);
    chk("t2_rdata", 32'(bus.rdata), 32'hA011);
    chk("t2_active", 32'(bus.dbg_active), 32'h0);
    cyc();
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 16'h0000;
    bus.dbg_wdata = 16'hCAFE;
    #2;
    chk("t3_active", 32'(bus.dbg_active), 32'h1);
    chk("t3_gnt", 32'(gnts()), 32'b001);
    chk("t3_wren", 32'(bus.ram_wren), 32'h1);
    chk("t3_addr", 32'(bus.ram_addr), 32'h0000);
    chk("t3_wdata", 32'(bus.ram_wdata), 32'hCAFE);
    chk("t3_rv", 32'(rvs()), 32'b000);
    cyc();
    bus.dbg_we = 1'b0;
    #2;
    chk("t4_gnt", 32'(gnts()), 32'b001);
    chk("t4_wren", 32'(bus.ram_wren), 32'h0);
    cyc();
    bus.dbg_hold = 1'b0;
    #2;
    chk("t5_gnt", 32'(gnts()), 32'b001);
    chk("t5_rv", 32'(rvs()), 32'b001);
    chk("t5_rdata", 32'(bus.rdata), 32'hCAFE);
    chk("t5_active", 32'(bus.dbg_active), 32'h1);
    cyc();
    bus.dbg_req = 1'b0;
    #2;
    chk("t6_gnt", 32'(gnts()), 32'b000);
    chk("t6_rv", 32'(rvs()), 32'b001);
    chk("t6_rdata", 32'(bus.rdata), 32'hCAFE);
    chk("t6_active", 32'(bus.dbg_active), 32'h1);
    cyc(); #2;
    chk("t7_active", 32'(bus.dbg_active), 32'h0);
    chk("t7_gnt", 32'(gnts()), 32'b100);
    chk("t7_addr", 32'(bus.ram_addr), 32'h0012);
    cyc();
    bus.if_req = 1'b0;
    #2;
    chk("t8_rv", 32'(rvs()), 32'b100);
    chk("t8_rdata", 32'(bus.rdata), 32'hA012);

    // Asynchronous reset in the middle of a read return
    cyc();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0013;
    #2;
    chk("r1_gnt", 32'(gnts()), 32'b100);
    cyc();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0200;
    #2;
    chk("r2_gnt", 32'(gnts()), 32'b010);
    chk("r2_rv", 32'(rvs()), 32'b100);
    reset_n = 1'b0;
    #1;
    chk("r2_rst_gnt", 32'(gnts()), 32'b000);
    chk("r2_rst_rv", 32'(rvs()), 32'b000);
    chk("r2_rst_addr", 32'(bus.ram_addr), 32'h0000);
    cyc();
    reset_n = 1'b1;
    #2;
    chk("r3_gnt", 32'(gnts()), 32'b100);
    chk("r3_rv", 32'(rvs()), 32'b000);
    chk("r3_active", 32'(bus.dbg_active), 32'h0);
    cyc(); #2;
    chk("r4_gnt", 32'(gnts()), 32'b010);
    chk("r4_rv", 32'(rvs()), 32'b100);
    chk("r4_rdata", 32'(bus.rdata), 32'hA013);
    cyc();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    #2;
    chk("r5_rv", 32'(rvs()), 32'b010);
    chk("r5_rdata", 32'(bus.rdata), 32'hA200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
